// File: rtl/sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_draw_scheduler
//
// Frame-level sequencer for the single VGA plot port. A frame_tick starts a
// frame. The frame first clears the playfield to BG_COLOUR one pixel per
// cycle in raster order. It then runs one shared ROM-backed sprite drawer over
// each valid sprite slot, in slot order.
//
// Ports
//   clk, reset      clock (posedge) and asynchronous active-low reset
//   frame_tick      1-cycle frame start request
//   sprite_valid    per-slot draw enable, sampled when the slot is loaded
//   sprite_x/_y     packed per-slot origins: x in [8i+7:8i], y in [7i+6:7i]
//   drawer_en       drawer enable; low for one or more cycles rewinds the drawer
//   drawer_xin/yin  latched origin of the slot currently being drawn
//   drawer_x/y      drawer's current pixel position (address phase)
//   drawer_colour   ROM colour, one cycle behind drawer_x/y
//   vga_*           pixel port to the VGA adapter (vga_plot = write strobe)
//   busy            high in every non-idle cycle of a frame, DONE included
//   frame_done      1-cycle pulse in the DONE cycle
//   frame_overrun   high in any cycle where frame_tick arrives while busy
//   dbg_state       current FSM state, for observation only
//
// Handshake: frame_tick is a fire-and-forget request. It is accepted only in
// IDLE. A tick in any other cycle is dropped, and frame_overrun flags that
// cycle. The vga_* signals form a one-way strobe: the pixel is valid exactly
// in the cycles where vga_plot is high, and there is no back-pressure.
// ---------------------------------------------------------------------------
module sprite_draw_scheduler #(
    parameter int         NUM_SPRITES = 4,
    parameter int         SPRITE_W    = 21,
    parameter int         SPRITE_H    = 30,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] BG_COLOUR   = 3'b000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic [NUM_SPRITES-1:0]   sprite_valid,
    input  logic [8*NUM_SPRITES-1:0] sprite_x,
    input  logic [7*NUM_SPRITES-1:0] sprite_y,
    output logic                     drawer_en,
    output logic [7:0]               drawer_xin,
    output logic [6:0]               drawer_yin,
    input  logic [7:0]               drawer_x,
    input  logic [6:0]               drawer_y,
    input  logic [2:0]               drawer_colour,
    output logic [7:0]               vga_x,
    output logic [6:0]               vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     frame_overrun,
    output logic [2:0]               dbg_state
);

    localparam int SLOT_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int AREA   = SPRITE_W * SPRITE_H;
    localparam int CNT_W  = $clog2(AREA + 1);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(AREA);
    localparam logic [7:0]        X_LAST    = 8'(SCREEN_W - 1);
    localparam logic [6:0]        Y_LAST    = 7'(SCREEN_H - 1);
    localparam logic [8:0]        X_LIMIT   = 9'(SCREEN_W);
    localparam logic [7:0]        Y_LIMIT   = 8'(SCREEN_H);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAW  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          cx_q, cx_d;
    logic [6:0]          cy_q, cy_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          xin_q, xin_d;
    logic [6:0]          yin_q, yin_d;
    logic [7:0]          px_q, px_d;
    logic [6:0]          py_q, py_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                en_q, en_d;

    // Unpacked views of the packed per-slot position buses.
    logic [7:0] slot_x [NUM_SPRITES];
    logic [6:0] slot_y [NUM_SPRITES];

    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            slot_x[i] = sprite_x[8*i +: 8];
            slot_y[i] = sprite_y[7*i +: 7];
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        xin_d   = xin_q;
        yin_d   = yin_q;

        // The drawer's position is delayed one stage so it lines up with
        // drawer_colour, which the ROM returns one cycle after the address.
        px_d    = drawer_x;
        py_d    = drawer_y;

        case (state_q)
            S_IDLE: begin
                if (frame_tick) begin
                    state_d = S_CLEAR;
                    cx_d    = 8'd0;
                    cy_d    = 7'd0;
                end
            end
            S_CLEAR: begin
                if (cx_q == X_LAST) begin
                    cx_d = 8'd0;
                    if (cy_q == Y_LAST) begin
                        state_d = S_LOAD;
                        slot_d  = '0;
                    end else begin
                        cy_d = cy_q + 7'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            S_LOAD: begin
                if (sprite_valid[slot_q]) begin
                    xin_d   = slot_x[slot_q];
                    yin_d   = slot_y[slot_q];
                    cnt_d   = '0;
                    state_d = S_DRAW;
                end else if (slot_q == SLOT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            S_DRAW: begin
                // There are AREA+1 cycles in DRAW. Cycle 0 only primes the
                // ROM pipeline. Cycles 1..AREA carry one pixel per ROM address.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                // drawer_en is low here, so the drawer rewinds before the next sprite.
                if (slot_q == SLOT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    slot_d  = slot_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        en_d   = (state_d == S_DRAW);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cx_q    <= 8'd0;
            cy_q    <= 7'd0;
            slot_q  <= '0;
            cnt_q   <= '0;
            xin_q   <= 8'd0;
            yin_q   <= 7'd0;
            px_q    <= 8'd0;
            py_q    <= 7'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            xin_q   <= xin_d;
            yin_q   <= yin_d;
            px_q    <= px_d;
            py_q    <= py_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            en_q    <= en_d;
        end
    end

    assign drawer_en     = en_q;
    assign drawer_xin    = xin_q;
    assign drawer_yin    = yin_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign dbg_state     = state_q;

    // The overrun flag must be visible in the same cycle as the rejected tick,
    // so it is decoded directly from the input.
    assign frame_overrun = frame_tick & busy_q;

    // Pixel port multiplexer. Clipping uses the wrapped 8/7-bit coordinates,
    // so a sprite that runs past 255/127 reappears on the left/top edge.
    always_comb begin
        vga_x      = 8'd0;
        vga_y      = 7'd0;
        vga_colour = 3'd0;
        vga_plot   = 1'b0;
        case (state_q)
            S_CLEAR: begin
                vga_x      = cx_q;
                vga_y      = cy_q;
                vga_colour = BG_COLOUR;
                vga_plot   = 1'b1;
            end
            S_DRAW: begin
                vga_x      = px_q;
                vga_y      = py_q;
                vga_colour = drawer_colour;
                vga_plot   = (cnt_q != '0) && ({1'b0, px_q} < X_LIMIT)
                             && ({1'b0, py_q} < Y_LIMIT);
            end
            default: begin
                vga_plot = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
module tb_sprite_draw_scheduler;

  localparam int NS   = 4;
  localparam int SW   = 21;
  localparam int SH   = 30;
  localparam int SCRW = 160;
  localparam int SCRH = 120;
  localparam int AREA = SW * SH;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            frame_tick = 1'b0;
  logic [NS-1:0]   sprite_valid = '0;
  logic [8*NS-1:0] sprite_x = '0;
  logic [7*NS-1:0] sprite_y = '0;
  logic            drawer_en;
  logic [7:0]      drawer_xin;
  logic [6:0]      drawer_yin;
  logic [7:0]      drawer_x;
  logic [6:0]      drawer_y;
  logic [2:0]      drawer_colour;
  logic [7:0]      vga_x;
  logic [6:0]      vga_y;
  logic [2:0]      vga_colour;
  logic            vga_plot;
  logic            busy;
  logic            frame_done;
  logic            frame_overrun;
  logic [2:0]      dbg_state;

  always #5 clk = ~clk;

  sprite_draw_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .sprite_valid  (sprite_valid),
    .sprite_x      (sprite_x),
    .sprite_y      (sprite_y),
    .drawer_en     (drawer_en),
    .drawer_xin    (drawer_xin),
    .drawer_yin    (drawer_yin),
    .drawer_x      (drawer_x),
    .drawer_y      (drawer_y),
    .drawer_colour (drawer_colour),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_colour    (vga_colour),
    .vga_plot      (vga_plot),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .dbg_state     (dbg_state)
  );

  // ---------------- sprite drawer environment model ----------------
  // Counters rewind whenever drawer_en is low. The ROM is read synchronously,
  // so the colour appears one cycle after its address.
  logic [2:0] rom [AREA];
  logic [7:0] d_xc = '0;
  logic [6:0] d_yc = '0;
  int         d_addr = 0;
  logic [2:0] d_col = '0;

  always @(posedge clk) begin
    if (!drawer_en) begin
      d_xc   <= '0;
      d_yc   <= '0;
      d_addr <= 0;
    end else begin
      if (d_xc == 8'(SW - 1)) begin
        d_xc <= '0;
        d_yc <= d_yc + 7'd1;
      end else begin
        d_xc <= d_xc + 8'd1;
      end
      d_addr <= d_addr + 1;
    end
    d_col <= (d_addr < AREA) ? rom[d_addr] : 3'd0;
  end

  assign drawer_x      = drawer_xin + d_xc;
  assign drawer_y      = drawer_yin + d_yc;
  assign drawer_colour = d_col;

  // ---------------- scoreboard ----------------
  logic [17:0] exp_q[$];     // {x, y, colour} in plot order
  logic [14:0] org_q[$];     // {xin, yin} expected per drawn sprite
  int checks   = 0;
  int failures = 0;
  int px [NS];
  int py [NS];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference frame model. It builds the expected plot stream and returns
  // the cycle (counted from the tick cycle) in which DONE must appear.
  function automatic int build_frame(input logic [NS-1:0] v);
    int len;
    int x;
    int y;
    exp_q.delete();
    org_q.delete();
    for (int yy = 0; yy < SCRH; yy++)
      for (int xx = 0; xx < SCRW; xx++)
        exp_q.push_back({8'(xx), 7'(yy), 3'b000});
    len = SCRW * SCRH;
    for (int i = 0; i < NS; i++) begin
      if (v[i]) begin
        len += AREA + 3;
        org_q.push_back({8'(px[i]), 7'(py[i])});
        for (int j = 0; j < AREA; j++) begin
          x = (px[i] + j % SW) % 256;
          y = (py[i] + j / SW) % 128;
          if (x < SCRW && y < SCRH) exp_q.push_back({8'(x), 7'(y), rom[j]});
        end
      end else begin
        len += 1;
      end
    end
    return len + 1;
  endfunction

  function automatic int count_ones(input logic [NS-1:0] v);
    int n = 0;
    for (int i = 0; i < NS; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic drive_positions();
    for (int i = 0; i < NS; i++) begin
      sprite_x[8*i +: 8] = 8'(px[i]);
      sprite_y[7*i +: 7] = 7'(py[i]);
    end
  endtask

  // Drivers and monitors work on the falling edge. At each falling edge the
  // outputs of cycle k are sampled first, then the inputs for cycle k are driven.
  task automatic run_frame(input logic [NS-1:0] v, input bit do_overrun, input bit do_scramble);
    int   exp_len;
    int   k;
    bit   seen;
    int   en_cycles;
    int   en_runs;
    logic prev_en;
    logic [17:0] want;
    logic [14:0] want_org;
    exp_len = build_frame(v);
    @(negedge clk);
    sprite_valid = v;
    drive_positions();
    frame_tick = 1'b1;
    k = 0; seen = 0; en_cycles = 0; en_runs = 0; prev_en = 1'b0;
    while (!seen && k < exp_len + 50) begin
      @(negedge clk);
      k++;
      frame_tick = 1'b0;
      if (k == 1) chk("busy_start", busy, 1);
      if (vga_plot) begin
        chk("plot_expected", exp_q.size() != 0, 1);
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 18'h0;
        chk("plot_xyc", {vga_x, vga_y, vga_colour}, want);
      end
      if (drawer_en && !prev_en) begin
        en_runs++;
        want_org = (org_q.size() != 0) ? org_q.pop_front() : 15'h7fff;
        chk("drawer_origin", {drawer_xin, drawer_yin}, want_org);
      end
      if (drawer_en) en_cycles++;
      prev_en = drawer_en;
      if (frame_done) seen = 1;
      if (do_overrun && k == 5) begin
        frame_tick = 1'b1;
        #1 chk("overrun_pulse", frame_overrun, 1);
      end
      if (do_overrun && k == 6) begin
        #1 chk("overrun_clear", frame_overrun, 0);
      end
      if (do_scramble && v[0] && k == SCRW * SCRH + 2) begin
        sprite_x[7:0] = sprite_x[7:0] + 8'd37;
        sprite_y[6:0] = sprite_y[6:0] + 7'd11;
      end
    end
    chk("done_seen", seen, 1);
    chk("done_cycle", k, exp_len);
    chk("busy_in_done", busy, 1);
    chk("plots_left", exp_q.size(), 0);
    chk("en_cycles", en_cycles, count_ones(v) * (AREA + 1));
    chk("en_runs", en_runs, count_ones(v));
    if (do_overrun) begin
      frame_tick = 1'b1;
      #1 chk("overrun_in_done", frame_overrun, 1);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    chk("idle_after_done", {busy, frame_done, vga_plot}, 0);
    repeat (5) begin
      @(negedge clk);
      chk("no_restart", {busy, vga_plot, drawer_en}, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk(tag, {vga_plot, vga_x, vga_y, vga_colour, drawer_en, drawer_xin, drawer_yin,
              busy, frame_done, frame_overrun, dbg_state}, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int wait_draw;
    for (int j = 0; j < AREA; j++) rom[j] = 3'($urandom_range(0, 7));
    for (int i = 0; i < NS; i++) begin
      px[i] = 0;
      py[i] = 0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("idle_outputs");

    // Frame with no sprites, a second tick 5 cycles in, and a tick in DONE.
    for (int i = 0; i < NS; i++) begin
      px[i] = $urandom_range(0, 255);
      py[i] = $urandom_range(0, 127);
    end
    run_frame(4'b0000, 1'b1, 1'b0);

    // Sprites with random positions: slot 1 clips at the bottom-right, slot 3
    // wraps past x=255, and slot 2 is skipped. Slot 0's input moves mid-draw.
    px[0] = $urandom_range(0, 139); py[0] = $urandom_range(0, 90);
    px[1] = 150;                    py[1] = 110;
    px[2] = $urandom_range(0, 255); py[2] = $urandom_range(0, 127);
    px[3] = $urandom_range(245, 255); py[3] = $urandom_range(0, 127);
    run_frame(4'b1011, 1'b0, 1'b1);

    // Reset in the middle of a DRAW.
    px[0] = $urandom_range(0, 255); py[0] = $urandom_range(0, 127);
    @(negedge clk);
    sprite_valid = 4'b0001;
    drive_positions();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    k = 0;
    while (!drawer_en && k < SCRW * SCRH + 50) begin
      @(negedge clk);
      k++;
    end
    chk("reach_draw", drawer_en, 1);
    wait_draw = $urandom_range(10, 600);
    repeat (wait_draw) @(negedge clk);
    reset = 1'b0;
    #1 check_all_zero("reset_mid_draw");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_after_reset", {busy, frame_done, vga_plot, drawer_en}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
